// File: rtl/max_pool_pkg.sv
// Shared CNN address map, default feature-map dimensions and the fmap address packing helper.
package max_pool_pkg;

  localparam int unsigned FMAP_BASE        = 131072;
  localparam int unsigned POOL_BASE        = 147456;
  localparam int unsigned DEF_FMAP_WIDTH   = 10;
  localparam int unsigned DEF_FMAP_HEIGHT  = 10;
  localparam int unsigned DEF_FMAP_DEPTH   = 16;

  // Feature maps are laid out as {channel, row, column} with a fixed 32x32 plane per channel.
  function automatic logic [13:0] fmap_offset(input logic [3:0] d, input logic [4:0] y,
                                              input logic [4:0] x);
    return {d, y, x};
  endfunction

endpackage

// File: rtl/max_pool_signed_max.sv
// Combinational two's-complement maximum; ties return the common value.
module signed_max #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = ($signed(a) >= $signed(b)) ? a : b;
  end

endmodule

// File: rtl/max_pool.sv
// 2x2 stride-2 signed max-pooling over a DRAM-resident feature map.
// One read per EVAL cycle (fixed 1-cycle latency); one write per completed window.
module max_pool
  import max_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 18,
  parameter int unsigned IN_BASE     = FMAP_BASE,
  parameter int unsigned OUT_BASE    = POOL_BASE,
  parameter int unsigned FMAP_WIDTH  = DEF_FMAP_WIDTH,
  parameter int unsigned FMAP_HEIGHT = DEF_FMAP_HEIGHT,
  parameter int unsigned FMAP_DEPTH  = DEF_FMAP_DEPTH
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_DRAIN, ST_DONE} state_t;

  localparam logic [3:0] OX_MAX = 4'(FMAP_WIDTH / 2 - 1);
  localparam logic [3:0] OY_MAX = 4'(FMAP_HEIGHT / 2 - 1);
  localparam logic [3:0] D_MAX  = 4'(FMAP_DEPTH - 1);

  state_t                state;
  logic [1:0]            ph, ph_ff;
  logic [3:0]            ox, oy, d, ox_ff, oy_ff, d_ff;
  logic                  rd_vld_ff;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] max_val;
  logic                  last_read;
  logic                  wr_now;
  logic                  unused_dram_valid;

  assign unused_dram_valid = dram_valid;

  assign last_read = (ph == 2'd3) && (ox == OX_MAX) && (oy == OY_MAX) && (d == D_MAX);

  signed_max #(.DATA_WIDTH(DATA_WIDTH)) u_signed_max (
    .a (acc),
    .b (data_in),
    .y (max_val)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state     <= ST_IDLE;
      ph        <= '0;
      ox        <= '0;
      oy        <= '0;
      d         <= '0;
      ph_ff     <= '0;
      ox_ff     <= '0;
      oy_ff     <= '0;
      d_ff      <= '0;
      rd_vld_ff <= 1'b0;
      acc       <= '0;
    end else begin
      rd_vld_ff <= (state == ST_EVAL);
      ph_ff     <= ph;
      ox_ff     <= ox;
      oy_ff     <= oy;
      d_ff      <= d;

      // The read issued last cycle returns now; phase 3 is consumed by the write path instead.
      if (rd_vld_ff) begin
        if (ph_ff == 2'd0) begin
          acc <= data_in;
        end else if (ph_ff != 2'd3) begin
          acc <= max_val;
        end
      end

      case (state)
        ST_IDLE: begin
          ph <= '0;
          ox <= '0;
          oy <= '0;
          d  <= '0;
          if (enable) begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          ph <= ph + 2'd1;
          if (ph == 2'd3) begin
            if (ox == OX_MAX) begin
              ox <= '0;
              if (oy == OY_MAX) begin
                oy <= '0;
                d  <= (d == D_MAX) ? 4'd0 : d + 4'd1;
              end else begin
                oy <= oy + 4'd1;
              end
            end else begin
              ox <= ox + 4'd1;
            end
          end
          if (last_read) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign wr_now = rd_vld_ff && (ph_ff == 2'd3);

  always_comb begin
    dram_en_rd = (state == ST_EVAL);
    addr_in    = '0;
    if (state == ST_EVAL) begin
      addr_in = ADDR_WIDTH'(IN_BASE) + ADDR_WIDTH'(fmap_offset(d, {oy, ph[1]}, {ox, ph[0]}));
    end
    dram_en_wr = wr_now;
    data_out   = wr_now ? max_val : '0;
    addr_out   = '0;
    if (wr_now) begin
      addr_out = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(fmap_offset(d_ff, {1'b0, oy_ff}, {1'b0, ox_ff}));
    end
    done = (state == ST_DONE);
  end

endmodule
